// File: rtl/altera_up_ext_bus_pkg.sv
// Shared types and helpers for the posted-write Avalon to external bus bridge.
package altera_up_ext_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUS  = 2'd1,
    RD_BUS  = 2'd2,
    RD_DONE = 2'd3
  } state_t;

  localparam int EXT_ADDR_BITS = 32;

  // Byte address on the external bus: the word address shifted up by the word byte offset.
  function automatic logic [EXT_ADDR_BITS-1:0] form_address(
    input logic [EXT_ADDR_BITS-1:0] word_addr,
    input int                       addr_low
  );
    return word_addr << addr_low;
  endfunction

endpackage

// File: rtl/altera_up_ext_bus_write_fifo.sv
// Synchronous posted-write FIFO; pointers carry one extra wrap bit so full and
// empty are told apart by the MSB. A push is refused while full, even with a pop.
module altera_up_ext_bus_write_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s, do_pop_s;

  assign full_o    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign data_o    = mem_q[rd_ptr_q[PW-1:0]];

  // Pointer update with synchronous reset discarding every queued entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + {{PW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + {{PW{1'b0}}, 1'b1};
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q[PW-1:0]] <= data_i;
  end

endmodule

// File: rtl/altera_up_avalon_ext_bus_bridge_posted.sv
// Avalon-MM slave to enable/acknowledge external bus bridge with posted writes and
// acknowledge timeout. Optional feature macro: EXT_BUS_TIMEOUT_ERROR_EN.
module altera_up_avalon_ext_bus_bridge_posted
  import altera_up_ext_bus_pkg::*;
#(
  parameter int ADDR_BITS      = 18,
  parameter int DATA_BITS      = 16,
  parameter int ADDR_LOW       = 1,
  parameter int BYTE_EN_BITS   = 2,
  parameter int WFIFO_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_BITS-1:0]     avalon_address,
  input  logic [BYTE_EN_BITS-1:0]  avalon_byteenable,
  input  logic                     avalon_chipselect,
  input  logic                     avalon_read,
  input  logic                     avalon_write,
  input  logic [DATA_BITS-1:0]     avalon_writedata,
  output logic [DATA_BITS-1:0]     avalon_readdata,
  output logic                     avalon_waitrequest,
  input  logic                     acknowledge,
  input  logic [DATA_BITS-1:0]     read_data,
  output logic [EXT_ADDR_BITS-1:0] address,
  output logic                     bus_enable,
  output logic [BYTE_EN_BITS-1:0]  byte_enable,
  output logic                     rw,
  output logic [DATA_BITS-1:0]     write_data
`ifdef EXT_BUS_TIMEOUT_ERROR_EN
  ,
  output logic                     timeout_error
`endif
);

  localparam int ENTRY_BITS = ADDR_BITS + BYTE_EN_BITS + DATA_BITS;

  logic                     read_req_s, write_req_s, push_s, pop_s, full_s, empty_s;
  logic                     last_cycle_s, complete_s;
  logic [ENTRY_BITS-1:0]    push_entry_s, head_entry_s;
  logic [ADDR_BITS-1:0]     head_addr_s;
  logic [BYTE_EN_BITS-1:0]  head_be_s;
  logic [DATA_BITS-1:0]     head_data_s;

  state_t                   state_q, state_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [EXT_ADDR_BITS-1:0] addr_q, addr_d;
  logic [BYTE_EN_BITS-1:0]  be_q, be_d;
  logic [DATA_BITS-1:0]     wdata_q, wdata_d;
  logic [DATA_BITS-1:0]     rdata_q, rdata_d;
  logic                     rw_q, rw_d;
  logic                     ben_q, ben_d;
`ifdef EXT_BUS_TIMEOUT_ERROR_EN
  logic                     terr_q, terr_d;
`endif

  assign read_req_s   = avalon_chipselect & avalon_read;
  assign write_req_s  = avalon_chipselect & avalon_write & ~avalon_read;
  assign push_s       = write_req_s & ~full_s;
  assign push_entry_s = {avalon_address, avalon_byteenable, avalon_writedata};
  assign {head_addr_s, head_be_s, head_data_s} = head_entry_s;

  assign last_cycle_s = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign complete_s   = acknowledge | last_cycle_s;

  altera_up_ext_bus_write_fifo #(
    .WIDTH (ENTRY_BITS),
    .DEPTH (WFIFO_DEPTH)
  ) u_write_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (push_entry_s),
    .data_o  (head_entry_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Transaction FSM: posted writes drain before any read is issued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    ben_d   = ben_q;
    pop_s   = 1'b0;
`ifdef EXT_BUS_TIMEOUT_ERROR_EN
    terr_d  = terr_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (!empty_s) begin
          pop_s   = 1'b1;
          addr_d  = form_address(EXT_ADDR_BITS'(head_addr_s), ADDR_LOW);
          be_d    = head_be_s;
          wdata_d = head_data_s;
          rw_d    = 1'b0;
          ben_d   = 1'b1;
          state_d = WR_BUS;
        end else if (read_req_s) begin
          addr_d  = form_address(EXT_ADDR_BITS'(avalon_address), ADDR_LOW);
          be_d    = avalon_byteenable;
          rw_d    = 1'b1;
          ben_d   = 1'b1;
          state_d = RD_BUS;
        end else begin
          rw_d  = 1'b1;
          ben_d = 1'b0;
        end
      end
      WR_BUS, RD_BUS: begin
        if (complete_s) begin
          cnt_d   = 16'd0;
          rw_d    = 1'b1;
          ben_d   = 1'b0;
          state_d = (state_q == RD_BUS) ? RD_DONE : IDLE;
          if (state_q == RD_BUS) begin
`ifdef EXT_BUS_TIMEOUT_ERROR_EN
            rdata_d = (acknowledge) ? read_data : {DATA_BITS{1'b1}};
`else
            rdata_d = read_data;
`endif
          end else begin
            rdata_d = rdata_q;
          end
`ifdef EXT_BUS_TIMEOUT_ERROR_EN
          if (!acknowledge) begin
            terr_d = 1'b1;
          end else begin
            terr_d = terr_q;
          end
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RD_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ben_d   = 1'b0;
        rw_d    = 1'b1;
      end
    endcase
  end

  // State and bus-output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b1;
      ben_q   <= 1'b0;
`ifdef EXT_BUS_TIMEOUT_ERROR_EN
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      ben_q   <= ben_d;
`ifdef EXT_BUS_TIMEOUT_ERROR_EN
      terr_q  <= terr_d;
`endif
    end
  end

  assign avalon_readdata    = rdata_q;
  assign address            = addr_q;
  assign bus_enable         = ben_q;
  assign byte_enable        = be_q;
  assign rw                 = rw_q;
  assign write_data         = wdata_q;
`ifdef EXT_BUS_TIMEOUT_ERROR_EN
  assign timeout_error      = terr_q;
`endif
  assign avalon_waitrequest = avalon_chipselect &
                              (reset | (avalon_write & ~avalon_read & full_s) |
                               (avalon_read & (state_q != RD_DONE)));

endmodule

// File: tb/tb_altera_up_avalon_ext_bus_bridge_posted.sv
// Directed bench for the posted-write external bus bridge (TIMEOUT_CYCLES = 8).
module tb_altera_up_avalon_ext_bus_bridge_posted;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] avalon_address;
  logic [1:0]  avalon_byteenable;
  logic        avalon_chipselect, avalon_read, avalon_write;
  logic [15:0] avalon_writedata;
  logic [15:0] avalon_readdata;
  logic        avalon_waitrequest;
  logic        acknowledge;
  logic        ack_drv, ack_auto;
  logic [15:0] read_data;
  logic [31:0] address;
  logic        bus_enable;
  logic [1:0]  byte_enable;
  logic        rw;
  logic [15:0] write_data;
`ifdef EXT_BUS_TIMEOUT_ERROR_EN
  logic        timeout_error;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Auto-acknowledge answers in the first bus cycle of every transaction.
  assign acknowledge = ack_drv | (ack_auto & bus_enable);

  altera_up_avalon_ext_bus_bridge_posted #(
    .ADDR_BITS(18), .DATA_BITS(16), .ADDR_LOW(1), .BYTE_EN_BITS(2),
    .WFIFO_DEPTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .avalon_address(avalon_address), .avalon_byteenable(avalon_byteenable),
    .avalon_chipselect(avalon_chipselect), .avalon_read(avalon_read),
    .avalon_write(avalon_write), .avalon_writedata(avalon_writedata),
    .avalon_readdata(avalon_readdata), .avalon_waitrequest(avalon_waitrequest),
    .acknowledge(acknowledge), .read_data(read_data),
    .address(address), .bus_enable(bus_enable), .byte_enable(byte_enable),
    .rw(rw), .write_data(write_data)
`ifdef EXT_BUS_TIMEOUT_ERROR_EN
    , .timeout_error(timeout_error)
`endif
  );

  // Bus-pulse monitor: records address/data/rw at each rising bus_enable and its length.
  int          pulse_len_q[$];
  logic [31:0] pulse_addr_q[$];
  logic [15:0] pulse_data_q[$];
  logic        pulse_rw_q[$];
  logic        mon_prev = 1'b0;
  int          mon_len = 0;
  always @(negedge clk) begin
    if (bus_enable && !mon_prev) begin
      pulse_addr_q.push_back(address);
      pulse_data_q.push_back(write_data);
      pulse_rw_q.push_back(rw);
      mon_len <= 1;
    end else if (bus_enable) begin
      mon_len <= mon_len + 1;
    end else if (mon_prev) begin
      pulse_len_q.push_back(mon_len);
    end
    mon_prev <= bus_enable;
  end

  typedef struct {
    logic        cs, rd, wr, ack;
    logic [17:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic        e_wait, e_ben, e_rw;
    logic [31:0] e_addr;
    logic [15:0] e_wdata;
    logic [1:0]  e_be;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    avalon_chipselect = 1'b0;
    avalon_read       = 1'b0;
    avalon_write      = 1'b0;
    ack_drv           = 1'b0;
  endtask

  // Hold a write until waitrequest is low; returns stall cycles (-1 on timeout).
  task automatic do_write(input logic [17:0] a, input logic [15:0] d, output int stalls);
    stalls = -1;
    avalon_chipselect = 1'b1; avalon_write = 1'b1; avalon_read = 1'b0;
    avalon_address = a; avalon_writedata = d; avalon_byteenable = 2'b11;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!avalon_waitrequest) begin
        stalls = i;
        next_slot();
        break;
      end
      next_slot();
    end
    if (stalls < 0) check("write_accept_timeout", 32'd0, 32'd1);
  endtask

  // Hold a read until waitrequest is low; returns stall cycles and the sampled readdata.
  task automatic do_read(input logic [17:0] a, input logic also_wr, output int stalls,
                         output logic [15:0] data);
    stalls = -1;
    data   = 16'h0;
    avalon_chipselect = 1'b1; avalon_read = 1'b1; avalon_write = also_wr;
    avalon_address = a; avalon_byteenable = 2'b01;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!avalon_waitrequest) begin
        stalls = i;
        data   = avalon_readdata;
        next_slot();
        break;
      end
      next_slot();
    end
    if (stalls < 0) check("read_accept_timeout", 32'd0, 32'd1);
    idle_bus();
  endtask

  initial begin
    int          st;
    int          base;
    logic [15:0] rd;
    int          exp_stall[6];

    // Single write (ack in 3rd bus cycle, stray ack while idle), then an immediate-ack read.
    vecs[0] = '{1'b1,1'b0,1'b1,1'b0,18'h00123,2'b11,16'hBEEF, 1'b0,1'b0,1'b1,32'h0,     16'h0,   2'b00,16'h0};
    vecs[1] = '{1'b0,1'b0,1'b0,1'b1,18'h00000,2'b00,16'h0000, 1'b0,1'b0,1'b1,32'h0,     16'h0,   2'b00,16'h0};
    vecs[2] = '{1'b0,1'b0,1'b0,1'b0,18'h00000,2'b00,16'h0000, 1'b0,1'b1,1'b0,32'h246,   16'hBEEF,2'b11,16'h0};
    vecs[3] = '{1'b0,1'b0,1'b0,1'b0,18'h00000,2'b00,16'h0000, 1'b0,1'b1,1'b0,32'h246,   16'hBEEF,2'b11,16'h0};
    vecs[4] = '{1'b0,1'b0,1'b0,1'b1,18'h00000,2'b00,16'h0000, 1'b0,1'b1,1'b0,32'h246,   16'hBEEF,2'b11,16'h0};
    vecs[5] = '{1'b0,1'b0,1'b0,1'b0,18'h00000,2'b00,16'h0000, 1'b0,1'b0,1'b1,32'h246,   16'hBEEF,2'b11,16'h0};
    vecs[6] = '{1'b1,1'b1,1'b0,1'b0,18'h00010,2'b01,16'h0000, 1'b1,1'b0,1'b1,32'h246,   16'hBEEF,2'b11,16'h0};
    vecs[7] = '{1'b1,1'b1,1'b0,1'b1,18'h00010,2'b01,16'h0000, 1'b1,1'b1,1'b1,32'h20,    16'hBEEF,2'b01,16'h0};
    vecs[8] = '{1'b1,1'b1,1'b0,1'b0,18'h00010,2'b01,16'h0000, 1'b0,1'b0,1'b1,32'h20,    16'hBEEF,2'b01,16'hA5C3};
    vecs[9] = '{1'b0,1'b0,1'b0,1'b0,18'h00000,2'b00,16'h0000, 1'b0,1'b0,1'b1,32'h20,    16'hBEEF,2'b01,16'hA5C3};

    reset = 1'b1; ack_auto = 1'b0; read_data = 16'hA5C3;
    avalon_address = '0; avalon_byteenable = '0; avalon_writedata = '0;
    idle_bus();
    next_slot();
    avalon_chipselect = 1'b1;
    @(negedge clk);
    check("reset_waitrequest", {31'd0, avalon_waitrequest}, 32'd1);
    check("reset_bus_enable", {31'd0, bus_enable}, 32'd0);
    check("reset_rw", {31'd0, rw}, 32'd1);
    next_slot();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      avalon_chipselect = vecs[i].cs; avalon_read = vecs[i].rd; avalon_write = vecs[i].wr;
      ack_drv = vecs[i].ack; avalon_address = vecs[i].addr;
      avalon_byteenable = vecs[i].be; avalon_writedata = vecs[i].wdata;
      @(negedge clk);
      check($sformatf("v%0d_waitrequest", i), {31'd0, avalon_waitrequest}, {31'd0, vecs[i].e_wait});
      check($sformatf("v%0d_bus_enable", i), {31'd0, bus_enable}, {31'd0, vecs[i].e_ben});
      check($sformatf("v%0d_rw", i), {31'd0, rw}, {31'd0, vecs[i].e_rw});
      check($sformatf("v%0d_address", i), address, vecs[i].e_addr);
      check($sformatf("v%0d_write_data", i), {16'd0, write_data}, {16'd0, vecs[i].e_wdata});
      check($sformatf("v%0d_byte_enable", i), {30'd0, byte_enable}, {30'd0, vecs[i].e_be});
      check($sformatf("v%0d_readdata", i), {16'd0, avalon_readdata}, {16'd0, vecs[i].e_rdata});
      next_slot();
    end
    idle_bus();
    check("table_pulse_count", pulse_len_q.size(), 32'd2);
    check("table_write_pulse_len", pulse_len_q[0], 32'd3);
    check("table_read_pulse_len", pulse_len_q[1], 32'd1);
`ifdef EXT_BUS_TIMEOUT_ERROR_EN
    check("no_timeout_yet", {31'd0, timeout_error}, 32'd0);
`endif

    // Six back-to-back writes, never acknowledged: the sixth waits on a full FIFO.
    exp_stall = '{0, 0, 0, 0, 0, 6};
    base = pulse_addr_q.size();
    for (int i = 0; i < 6; i++) begin
      do_write(18'h00100 + 18'(i), 16'h1000 + 16'(i), st);
      check($sformatf("burst_stall%0d", i), st, exp_stall[i]);
    end
    idle_bus();
    repeat (70) next_slot();
    check("burst_pulse_count", pulse_len_q.size() - base, 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("burst_len%0d", i), pulse_len_q[base+i], 32'd8);
      check($sformatf("burst_addr%0d", i), pulse_addr_q[base+i], 32'h200 + 32'(2*i));
      check($sformatf("burst_data%0d", i), {16'd0, pulse_data_q[base+i]}, 32'h1000 + 32'(i));
      check($sformatf("burst_rw%0d", i), {31'd0, pulse_rw_q[base+i]}, 32'd0);
    end
`ifdef EXT_BUS_TIMEOUT_ERROR_EN
    check("write_timeout_error", {31'd0, timeout_error}, 32'd1);
`endif

    // Read behind two posted writes, immediate acknowledge.
    ack_auto = 1'b1; read_data = 16'h1234;
    base = pulse_addr_q.size();
    do_write(18'h00300, 16'h0300, st);
    do_write(18'h00301, 16'h0301, st);
    do_read(18'h00310, 1'b0, st, rd);
    check("ordered_read_stalls", st, 32'd5);
    check("ordered_read_data", {16'd0, rd}, 32'h1234);
    next_slot();
    check("ordered_pulse_count", pulse_addr_q.size() - base, 32'd3);
    check("ordered_addr0", pulse_addr_q[base], 32'h600);
    check("ordered_addr1", pulse_addr_q[base+1], 32'h602);
    check("ordered_addr2", pulse_addr_q[base+2], 32'h620);
    check("ordered_rw2", {31'd0, pulse_rw_q[base+2]}, 32'd1);
    check("ordered_rw0", {31'd0, pulse_rw_q[base]}, 32'd0);

    // Read with no acknowledge times out after 8 bus cycles.
    ack_auto = 1'b0; read_data = 16'h5A5A;
    do_read(18'h00020, 1'b0, st, rd);
    check("timeout_read_stalls", st, 32'd9);
`ifdef EXT_BUS_TIMEOUT_ERROR_EN
    check("timeout_read_data", {16'd0, rd}, 32'hFFFF);
    check("timeout_error_set", {31'd0, timeout_error}, 32'd1);
`else
    check("timeout_read_data", {16'd0, rd}, 32'h5A5A);
`endif

    // Read and write both high: a read, with no posted write left behind.
    ack_auto = 1'b1; read_data = 16'h0F0F;
    next_slot();
    base = pulse_addr_q.size();
    do_read(18'h00040, 1'b1, st, rd);
    check("rdwr_stalls", st, 32'd2);
    check("rdwr_data", {16'd0, rd}, 32'h0F0F);
    repeat (10) next_slot();
    check("rdwr_pulse_count", pulse_addr_q.size() - base, 32'd1);
    check("rdwr_addr", pulse_addr_q[base], 32'h80);
    check("rdwr_rw", {31'd0, pulse_rw_q[base]}, 32'd1);

    // Reset in the middle of a write with three entries queued.
    ack_auto = 1'b0;
    for (int i = 0; i < 4; i++) do_write(18'h00400 + 18'(i), 16'h4000 + 16'(i), st);
    idle_bus();
    reset = 1'b1;
    @(negedge clk);
    check("pre_reset_bus_enable", {31'd0, bus_enable}, 32'd1);
    check("pre_reset_rw", {31'd0, rw}, 32'd0);
    next_slot();
    @(negedge clk);
    check("post_reset_bus_enable", {31'd0, bus_enable}, 32'd0);
    check("post_reset_rw", {31'd0, rw}, 32'd1);
    check("post_reset_address", address, 32'd0);
    next_slot();
    reset = 1'b0;
    next_slot();
    base = pulse_addr_q.size();
    repeat (40) next_slot();
    check("no_activity_after_reset", pulse_addr_q.size() - base, 32'd0);
    check("idle_bus_enable", {31'd0, bus_enable}, 32'd0);
    check("reset_readdata", {16'd0, avalon_readdata}, 32'd0);
`ifdef EXT_BUS_TIMEOUT_ERROR_EN
    check("reset_timeout_error", {31'd0, timeout_error}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
